reservation_station: RTL and testbench

- Tomasulo-style reservation station that sits between the operand managers (dispatch side) and one ALU (issue side).
- Buffers dispatched instructions whose operands are either values or pending ROB tags.
- Snoops the common data bus (CDB) to wake pending operands.
- Each cycle, selects one ready entry to issue to the shared ALU.
- Flush support for branch mispredict recovery.

---
 rtl/reservation_station_pkg.sv | 15 +
 rtl/rs_select.sv | 25 ++
 rtl/reservation_station.sv | 154 +++++++++++++++
 tb/tb_reservation_station.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared ROB tag width, data width and ALU op encodings
package reservation_station_pkg;
  localparam int ROB_ENTRY_WIDTH = 4;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_e;
endpackage

// File: rtl/rs_select.sv
// rs_select: oldest-eligible one-hot selector, ties resolved toward the lowest index
module rs_select #(
  parameter int N = 4,
  parameter int AW = 2
) (
  input  logic [N-1:0]    eligible,
  input  logic [N*AW-1:0] ages,
  output logic [N-1:0]    grant,
  output logic            valid
);
  logic [AW-1:0] best_age;
  always_comb begin
    grant = '0;
    valid = 1'b0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i] && (!valid || ages[i*AW +: AW] > best_age)) begin
        valid = 1'b1;
        best_age = ages[i*AW +: AW];
        grant = '0;
        grant[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: Tomasulo RS with CDB wakeup and oldest-first issue; RS_DISPATCH_BYPASS_EN adds same-cycle CDB capture at dispatch
module reservation_station import reservation_station_pkg::*; #(
  parameter int RS_DEPTH = 4,
  parameter int OP_WIDTH = 4,
  parameter int TAG_WIDTH = ROB_ENTRY_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [OP_WIDTH-1:0]         disp_op,
  input  logic [TAG_WIDTH-1:0]        disp_dest,
  input  logic                        disp_a_ready,
  input  logic [DATA_WIDTH-1:0]       disp_a_value,
  input  logic [TAG_WIDTH-1:0]        disp_a_tag,
  input  logic                        disp_b_ready,
  input  logic [DATA_WIDTH-1:0]       disp_b_value,
  input  logic [TAG_WIDTH-1:0]        disp_b_tag,
  input  logic                        cdb_valid,
  input  logic [TAG_WIDTH-1:0]        cdb_tag,
  input  logic [DATA_WIDTH-1:0]       cdb_value,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OP_WIDTH-1:0]         issue_op,
  output logic [DATA_WIDTH-1:0]       issue_a,
  output logic [DATA_WIDTH-1:0]       issue_b,
  output logic [TAG_WIDTH-1:0]        issue_dest,
  output logic [$clog2(RS_DEPTH):0]   occupancy
);
  localparam int AW = $clog2(RS_DEPTH);
  localparam int CW = AW + 1;
  logic [RS_DEPTH-1:0] busy_q, busy_d, a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic [RS_DEPTH-1:0] grant_q, grant_d, sel_grant, grant;
  logic lock_q, lock_d, sel_valid, disp_fire, a_byp, b_byp;
  logic [OP_WIDTH-1:0] op_q [RS_DEPTH];
  logic [OP_WIDTH-1:0] op_d [RS_DEPTH];
  logic [TAG_WIDTH-1:0] dest_q [RS_DEPTH];
  logic [TAG_WIDTH-1:0] dest_d [RS_DEPTH];
  logic [TAG_WIDTH-1:0] a_tag_q [RS_DEPTH];
  logic [TAG_WIDTH-1:0] a_tag_d [RS_DEPTH];
  logic [TAG_WIDTH-1:0] b_tag_q [RS_DEPTH];
  logic [TAG_WIDTH-1:0] b_tag_d [RS_DEPTH];
  logic [DATA_WIDTH-1:0] a_val_q [RS_DEPTH];
  logic [DATA_WIDTH-1:0] a_val_d [RS_DEPTH];
  logic [DATA_WIDTH-1:0] b_val_q [RS_DEPTH];
  logic [DATA_WIDTH-1:0] b_val_d [RS_DEPTH];
  logic [AW-1:0] age_q [RS_DEPTH];
  logic [AW-1:0] age_d [RS_DEPTH];
  logic [RS_DEPTH*AW-1:0] ages;
  logic [AW-1:0] free_idx;
`ifdef RS_DISPATCH_BYPASS_EN
  assign a_byp = ~disp_a_ready & cdb_valid & (disp_a_tag == cdb_tag);
  assign b_byp = ~disp_b_ready & cdb_valid & (disp_b_tag == cdb_tag);
`else
  assign a_byp = 1'b0;
  assign b_byp = 1'b0;
`endif
  always_comb begin
    ages = '0;
    for (int i = 0; i < RS_DEPTH; i++) ages[i*AW +: AW] = age_q[i];
  end
  rs_select #(.N(RS_DEPTH), .AW(AW)) u_select (
    .eligible(busy_q & a_rdy_q & b_rdy_q),
    .ages(ages),
    .grant(sel_grant),
    .valid(sel_valid)
  );
  // A stalled issue keeps its grant so late wakeups of older entries cannot swap the offer
  always_comb begin
    disp_ready = ~&busy_q;
    grant = lock_q ? grant_q : sel_grant;
    issue_valid = lock_q | sel_valid;
    issue_op = '0;
    issue_dest = '0;
    issue_a = '0;
    issue_b = '0;
    free_idx = '0;
    occupancy = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = AW'(i);
      if (grant[i]) begin
        issue_op = op_q[i];
        issue_dest = dest_q[i];
        issue_a = a_val_q[i];
        issue_b = b_val_q[i];
      end
      occupancy = occupancy + CW'(busy_q[i]);
    end
  end
  always_comb begin
    disp_fire = disp_valid & disp_ready & ~flush;
    busy_d = busy_q & ~((issue_valid & issue_ready) ? grant : '0);
    a_rdy_d = a_rdy_q;
    b_rdy_d = b_rdy_q;
    op_d = op_q;
    dest_d = dest_q;
    a_tag_d = a_tag_q;
    b_tag_d = b_tag_q;
    a_val_d = a_val_q;
    b_val_d = b_val_q;
    age_d = age_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cdb_valid && busy_q[i] && !a_rdy_q[i] && a_tag_q[i] == cdb_tag) begin
        a_rdy_d[i] = 1'b1;
        a_val_d[i] = cdb_value;
      end
      if (cdb_valid && busy_q[i] && !b_rdy_q[i] && b_tag_q[i] == cdb_tag) begin
        b_rdy_d[i] = 1'b1;
        b_val_d[i] = cdb_value;
      end
      if (disp_fire && busy_q[i] && age_q[i] != '1) age_d[i] = age_q[i] + AW'(1);
    end
    if (disp_fire) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx] = disp_op;
      dest_d[free_idx] = disp_dest;
      age_d[free_idx] = '0;
      a_rdy_d[free_idx] = disp_a_ready | a_byp;
      a_val_d[free_idx] = disp_a_ready ? disp_a_value : cdb_value;
      a_tag_d[free_idx] = disp_a_tag;
      b_rdy_d[free_idx] = disp_b_ready | b_byp;
      b_val_d[free_idx] = disp_b_ready ? disp_b_value : cdb_value;
      b_tag_d[free_idx] = disp_b_tag;
    end
    if (flush) busy_d = '0;
    lock_d = issue_valid & ~issue_ready & ~flush;
    grant_d = grant;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      a_rdy_q <= '0;
      b_rdy_q <= '0;
      lock_q <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      a_rdy_q <= a_rdy_d;
      b_rdy_q <= b_rdy_d;
      lock_q <= lock_d;
      age_q <= age_d;
    end
  end
  always_ff @(posedge clk) begin
    op_q <= op_d;
    dest_q <= dest_d;
    a_tag_q <= a_tag_d;
    b_tag_q <= b_tag_d;
    a_val_q <= a_val_d;
    b_val_q <= b_val_d;
    grant_q <= grant_d;
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed plan scenarios plus random traffic against a slot-level reference model
module tb_reservation_station;
  import reservation_station_pkg::*;
  localparam int N = 4;
  localparam int OW = 4;
  localparam int TW = ROB_ENTRY_WIDTH;
  logic clk = 1'b0;
  logic rst_n, flush, disp_valid, disp_ready, disp_a_ready, disp_b_ready;
  logic cdb_valid, issue_valid, issue_ready;
  logic [OW-1:0] disp_op, issue_op;
  logic [TW-1:0] disp_dest, disp_a_tag, disp_b_tag, cdb_tag, issue_dest;
  logic [31:0] disp_a_value, disp_b_value, cdb_value, issue_a, issue_b;
  logic [$clog2(N):0] occupancy;
  always #5 clk = ~clk;
  reservation_station #(.RS_DEPTH(N), .OP_WIDTH(OW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dest(disp_dest),
    .disp_a_ready(disp_a_ready), .disp_a_value(disp_a_value), .disp_a_tag(disp_a_tag),
    .disp_b_ready(disp_b_ready), .disp_b_value(disp_b_value), .disp_b_tag(disp_b_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_dest(issue_dest), .occupancy(occupancy)
  );
  typedef struct {
    bit busy;
    logic [OW-1:0] op;
    logic [TW-1:0] dest;
    bit ar;
    bit br;
    logic [31:0] av;
    logic [31:0] bv;
    logic [TW-1:0] at;
    logic [TW-1:0] bt;
    int age;
  } slot_t;
  slot_t m[N];
  bit hold;
  int held;
  int checks = 0;
  int failures = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int pick();
    int s = -1;
    if (hold) return held;
    for (int i = 0; i < N; i++)
      if (m[i].busy && m[i].ar && m[i].br && (s < 0 || m[i].age > m[s].age)) s = i;
    return s;
  endfunction
  task automatic idle();
    rst_n = 1'b1; flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b0;
    disp_op = '0; disp_dest = '0; disp_a_ready = 1'b0; disp_a_value = '0; disp_a_tag = '0;
    disp_b_ready = 1'b0; disp_b_value = '0; disp_b_tag = '0; cdb_tag = '0; cdb_value = '0;
  endtask
  task automatic disp(input logic [OW-1:0] op, input logic [TW-1:0] dest,
                      input bit ar, input logic [31:0] av, input logic [TW-1:0] at,
                      input bit br, input logic [31:0] bv, input logic [TW-1:0] bt);
    disp_valid = 1'b1; disp_op = op; disp_dest = dest;
    disp_a_ready = ar; disp_a_value = av; disp_a_tag = at;
    disp_b_ready = br; disp_b_value = bv; disp_b_tag = bt;
  endtask
  task automatic step();
    int s, cnt, fr;
    bit byp_a, byp_b;
    slot_t nx[N];
    #1;
    s = pick();
    cnt = 0;
    fr = 0;
    for (int i = N - 1; i >= 0; i--) if (!m[i].busy) fr = i;
    for (int i = 0; i < N; i++) cnt += int'(m[i].busy);
    check("disp_ready", 32'(disp_ready), 32'(cnt < N));
    check("occupancy", 32'(occupancy), cnt);
    check("issue_valid", 32'(issue_valid), 32'(s >= 0));
    if (s >= 0) begin
      check("issue_op", 32'(issue_op), 32'(m[s].op));
      check("issue_dest", 32'(issue_dest), 32'(m[s].dest));
      check("issue_a", issue_a, m[s].av);
      check("issue_b", issue_b, m[s].bv);
    end
    nx = m;
`ifdef RS_DISPATCH_BYPASS_EN
    byp_a = !disp_a_ready && cdb_valid && disp_a_tag == cdb_tag;
    byp_b = !disp_b_ready && cdb_valid && disp_b_tag == cdb_tag;
`else
    byp_a = 1'b0;
    byp_b = 1'b0;
`endif
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        nx[i].busy = 0; nx[i].ar = 0; nx[i].br = 0; nx[i].age = 0;
      end
      hold = 0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) nx[i].busy = 0;
      hold = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cdb_valid && m[i].busy && !m[i].ar && m[i].at == cdb_tag) begin nx[i].ar = 1; nx[i].av = cdb_value; end
        if (cdb_valid && m[i].busy && !m[i].br && m[i].bt == cdb_tag) begin nx[i].br = 1; nx[i].bv = cdb_value; end
      end
      if (s >= 0 && issue_ready) nx[s].busy = 0;
      if (disp_valid && cnt < N) begin
        for (int i = 0; i < N; i++) if (m[i].busy) nx[i].age = (m[i].age + 1 > N - 1) ? N - 1 : m[i].age + 1;
        nx[fr].busy = 1; nx[fr].op = disp_op; nx[fr].dest = disp_dest; nx[fr].age = 0;
        nx[fr].ar = disp_a_ready || byp_a; nx[fr].av = disp_a_ready ? disp_a_value : cdb_value; nx[fr].at = disp_a_tag;
        nx[fr].br = disp_b_ready || byp_b; nx[fr].bv = disp_b_ready ? disp_b_value : cdb_value; nx[fr].bt = disp_b_tag;
      end
      hold = s >= 0 && !issue_ready;
      held = s;
    end
    @(posedge clk);
    m = nx;
    @(negedge clk);
  endtask
  initial begin
    idle();
    rst_n = 1'b0;
    hold = 0;
    held = 0;
    for (int i = 0; i < N; i++) begin
      m[i].busy = 0; m[i].ar = 0; m[i].br = 0; m[i].age = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    step();
    check("rst_occ", 32'(occupancy), 0);
    check("rst_ready", 32'(disp_ready), 1);
    // plan 1: both operands ready at dispatch
    disp(ALU_ADD, 4'd1, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0);
    step();
    idle();
    check("t1_valid", 32'(issue_valid), 1);
    check("t1_a", issue_a, 32'd5);
    check("t1_b", issue_b, 32'd7);
    check("t1_occ1", 32'(occupancy), 1);
    issue_ready = 1'b1;
    step();
    idle();
    check("t1_occ0", 32'(occupancy), 0);
    // plan 2: CDB wakeup
    disp(ALU_SUB, 4'd2, 0, 32'd0, 4'd3, 1, 32'd9, 4'd0);
    step();
    idle();
    check("t2_wait", 32'(issue_valid), 0);
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_value = 32'h10;
    step();
    idle();
    check("t2_valid", 32'(issue_valid), 1);
    check("t2_a", issue_a, 32'h10);
    issue_ready = 1'b1;
    step();
    idle();
    // plan 3: fill, stall, drain in order
    for (int k = 0; k < N; k++) begin
      disp(OW'(k), TW'(4 + k), 1, 32'(k), 4'd0, 1, 32'(k + 100), 4'd0);
      step();
    end
    idle();
    check("t3_full", 32'(disp_ready), 0);
    check("t3_occ", 32'(occupancy), N);
    check("t3_first", 32'(issue_dest), 4);
    step();
    check("t3_stable", 32'(issue_dest), 4);
    for (int k = 0; k < N; k++) begin
      check("t3_order", 32'(issue_dest), 32'(4 + k));
      issue_ready = 1'b1;
      step();
    end
    idle();
    check("t3_empty", 32'(occupancy), 0);
    // plan 4: full with simultaneous issue and dispatch
    for (int k = 0; k < N; k++) begin
      disp(ALU_AND, TW'(k), 1, 32'(k), 4'd0, 1, 32'(k), 4'd0);
      step();
    end
    issue_ready = 1'b1;
    disp(ALU_OR, 4'd9, 1, 32'h99, 4'd0, 1, 32'h98, 4'd0);
    step();
    check("t4_reject", 32'(occupancy), N - 1);
    issue_ready = 1'b0;
    step();
    idle();
    check("t4_accept", 32'(occupancy), N);
    issue_ready = 1'b1;
    repeat (N) step();
    idle();
    // plan 5: flush drops a same-cycle dispatch
    for (int k = 0; k < 3; k++) begin
      disp(ALU_XOR, TW'(k), 1, 32'(k), 4'd0, 1, 32'(k), 4'd0);
      step();
    end
    disp(ALU_XOR, 4'd7, 1, 32'h7, 4'd0, 1, 32'h7, 4'd0);
    flush = 1'b1;
    step();
    idle();
    check("t5_occ", 32'(occupancy), 0);
    check("t5_valid", 32'(issue_valid), 0);
    step();
    // plan 6: dispatch overlapping a CDB broadcast of its pending tag
    disp(ALU_ADD, 4'd6, 0, 32'd0, 4'd5, 1, 32'd1, 4'd0);
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 32'h22;
    step();
    idle();
`ifdef RS_DISPATCH_BYPASS_EN
    check("t6_byp_valid", 32'(issue_valid), 1);
    check("t6_byp_a", issue_a, 32'h22);
`else
    check("t6_nobyp", 32'(issue_valid), 0);
`endif
    issue_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    idle();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      flush = ($urandom_range(0, 39) == 0);
      disp_valid = ($urandom_range(0, 9) < 6);
      disp_op = OW'($urandom);
      disp_dest = TW'($urandom);
      disp_a_ready = $urandom_range(0, 1) == 1;
      disp_b_ready = $urandom_range(0, 1) == 1;
      disp_a_value = $urandom;
      disp_b_value = $urandom;
      disp_a_tag = TW'($urandom_range(0, 3));
      disp_b_tag = TW'($urandom_range(0, 3));
      cdb_valid = $urandom_range(0, 1) == 1;
      cdb_tag = TW'($urandom_range(0, 3));
      cdb_value = $urandom;
      issue_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
